// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI write-side arbiter/framer: state codes,
// header field positions, source ids and the I/Q sign-extension helpers.
package ftdi_pkg;

    localparam int unsigned FT_DATA_WIDTH    = 32;
    localparam int unsigned IQ_PAIR_WIDTH    = 24;
    localparam int unsigned QSTART_BIT_INDEX = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_FIFO = 3'd2;
    localparam logic [2:0] ST_CPU  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int unsigned HDR_SRC_BIT      = 31;
    localparam int unsigned HDR_CPU_LEN_MSB  = 27;
    localparam int unsigned HDR_CPU_LEN_LSB  = 20;
    localparam int unsigned HDR_TAG_MSB      = 19;
    localparam int unsigned HDR_FIFO_LEN_MSB = 15;

    typedef enum logic {
        TOFIFO = 1'b0,
        TOCPU  = 1'b1
    } src_e;

    function automatic logic [15:0] sext12(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

    // I sits in the low half of the sample pair, Q in the high half.
    function automatic logic [FT_DATA_WIDTH-1:0] iq_to_word(input logic [IQ_PAIR_WIDTH-1:0] iq);
        logic [FT_DATA_WIDTH-1:0] w;
        w = '0;
        w[QSTART_BIT_INDEX +: 16] = sext12(iq[23:12]);
        w[15:0]                   = sext12(iq[11:0]);
        return w;
    endfunction

    function automatic logic [FT_DATA_WIDTH-1:0] fifo_header(input logic [15:0] n);
        logic [FT_DATA_WIDTH-1:0] h;
        h = '0;
        h[HDR_FIFO_LEN_MSB:0] = n;
        return h;
    endfunction

    function automatic logic [FT_DATA_WIDTH-1:0] cpu_header(input logic [7:0] n, input logic [19:0] tag);
        logic [FT_DATA_WIDTH-1:0] h;
        h = '0;
        h[HDR_SRC_BIT]                       = 1'b1;
        h[HDR_CPU_LEN_MSB:HDR_CPU_LEN_LSB]   = n;
        h[HDR_TAG_MSB:0]                     = tag;
        return h;
    endfunction

endpackage

// File: rtl/sel_a2f_arb_if.sv
// Bus bundle for the arbiter: FTDI write port, RX sample FIFO and ECPU mailbox.
interface sel_a2f_arb_if;
    import ftdi_pkg::*;

    logic                     ft_full_i;
    logic [FT_DATA_WIDTH-1:0] data_o;
    logic                     we_o;
    logic [IQ_PAIR_WIDTH-1:0] fifo_data_i;
    logic                     fifo_empty_i;
    logic                     fifo_enough_i;
    logic                     fifo_rd_o;
    logic                     cpu_req_i;
    logic [7:0]               cpu_len_i;
    logic [19:0]              cpu_tag_i;
    logic [FT_DATA_WIDTH-1:0] cpu_data_i;
    logic                     cpu_rd_o;
    logic                     cpu_ack_o;
    logic                     busy_o;

    modport slave (
        input  ft_full_i, fifo_data_i, fifo_empty_i, fifo_enough_i,
               cpu_req_i, cpu_len_i, cpu_tag_i, cpu_data_i,
        output data_o, we_o, fifo_rd_o, cpu_rd_o, cpu_ack_o, busy_o
    );

    modport master (
        output ft_full_i, fifo_data_i, fifo_empty_i, fifo_enough_i,
               cpu_req_i, cpu_len_i, cpu_tag_i, cpu_data_i,
        input  data_o, we_o, fifo_rd_o, cpu_rd_o, cpu_ack_o, busy_o
    );

endinterface

// File: rtl/out_reg_stage.sv
// One-entry output register for the FTDI write port. Reloads in the same
// cycle its word is accepted, so back-to-back words go out without bubbles.
module out_reg_stage
    import ftdi_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [FT_DATA_WIDTH-1:0] din,
    input  logic                     ft_full_i,
    output logic [FT_DATA_WIDTH-1:0] data_o,
    output logic                     valid,
    output logic                     we_o,
    output logic                     room
);

    assign we_o = valid & ~ft_full_i;
    assign room = ~valid | ~ft_full_i;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            valid  <= 1'b0;
            data_o <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            data_o <= din;
        end else if (we_o) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/sel_a2f_arb.sv
// FTDI transmit arbiter/framer: shares the write port between RX IQ bursts
// and ECPU messages, prefixing every burst with a demux header.
//
// state   | meaning
// ST_IDLE | arbitrate (or raw FIFO passthrough when loopback=1)
// ST_HDR  | load the header word for the granted source
// ST_FIFO | stream BURST_LEN sign-extended IQ words
// ST_CPU  | stream len ECPU payload words verbatim
// ST_DONE | wait for the output register to drain, ack the CPU
module sel_a2f_arb
    import ftdi_pkg::*;
#(
    parameter int unsigned BURST_LEN = 256
)(
    input  logic          clk_i,
    input  logic          reset_n,
    input  logic          loopback,
    sel_a2f_arb_if.slave  bus
);

    localparam logic [15:0] BURST_LIM = 16'(BURST_LEN);

    logic [2:0]               state, state_nxt;
    src_e                     src, last_src, grant_src;
    logic [7:0]               len_q;
    logic [19:0]              tag_q;
    logic [15:0]              count, count_nxt, limit;
    logic                     grant, done_exit, last_word;
    logic                     load, fifo_pop, cpu_pop, ack;
    logic [FT_DATA_WIDTH-1:0] din, fifo_word, data;
    logic                     valid, we, room_raw, room;

    out_reg_stage u_out (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .load      (load),
        .din       (din),
        .ft_full_i (bus.ft_full_i),
        .data_o    (data),
        .valid     (valid),
        .we_o      (we),
        .room      (room_raw)
    );

    // Held off during reset so the combinational pops stay low while reset_n is low.
    assign room      = room_raw & reset_n;
    assign fifo_word = iq_to_word(bus.fifo_data_i);
    assign limit     = (src == TOCPU) ? {8'd0, len_q} : BURST_LIM;
    assign last_word = (count + 16'd1) == limit;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        grant     = 1'b0;
        grant_src = src;
        load      = 1'b0;
        din       = '0;
        fifo_pop  = 1'b0;
        cpu_pop   = 1'b0;
        ack       = 1'b0;
        done_exit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (loopback) begin
                    if (room && !bus.fifo_empty_i) begin
                        load     = 1'b1;
                        din      = fifo_word;
                        fifo_pop = 1'b1;
                    end
                end else if (room && (bus.cpu_req_i || bus.fifo_enough_i)) begin
                    grant = 1'b1;
                    if (bus.cpu_req_i && bus.fifo_enough_i)
                        grant_src = (last_src == TOFIFO) ? TOCPU : TOFIFO;
                    else
                        grant_src = bus.cpu_req_i ? TOCPU : TOFIFO;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (room) begin
                    load = 1'b1;
                    if (src == TOCPU) begin
                        din       = cpu_header(len_q, tag_q);
                        state_nxt = (len_q == 8'd0) ? ST_DONE : ST_CPU;
                    end else begin
                        din       = fifo_header(BURST_LIM);
                        state_nxt = ST_FIFO;
                    end
                end
            end
            ST_FIFO: begin
                // An empty FIFO mid-burst just stalls; nothing is padded.
                if (room && !bus.fifo_empty_i) begin
                    load     = 1'b1;
                    din      = fifo_word;
                    fifo_pop = 1'b1;
                    if (last_word) begin
                        count_nxt = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        count_nxt = count + 16'd1;
                    end
                end
            end
            ST_CPU: begin
                if (room) begin
                    load    = 1'b1;
                    din     = bus.cpu_data_i;
                    cpu_pop = 1'b1;
                    if (last_word) begin
                        count_nxt = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        count_nxt = count + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!valid) begin
                    done_exit = 1'b1;
                    ack       = (src == TOCPU);
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            src      <= TOFIFO;
            last_src <= TOFIFO;
            len_q    <= '0;
            tag_q    <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (grant) begin
                src   <= grant_src;
                len_q <= bus.cpu_len_i;
                tag_q <= bus.cpu_tag_i;
            end
            if (done_exit)
                last_src <= src;
        end
    end

    assign bus.data_o    = data;
    assign bus.we_o      = we;
    assign bus.fifo_rd_o = fifo_pop;
    assign bus.cpu_rd_o  = cpu_pop;
    assign bus.cpu_ack_o = ack;
    assign bus.busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_sel_a2f_arb.sv
// Directed bench for sel_a2f_arb with BURST_LEN=4: FIFO bursts, CPU messages,
// round-robin ties, write-port backpressure, loopback and mid-burst reset.
module tb_sel_a2f_arb;

    logic clk;
    logic reset_n;
    logic loopback;

    sel_a2f_arb_if bus();

    sel_a2f_arb #(.BURST_LEN(4)) dut (
        .clk_i    (clk),
        .reset_n  (reset_n),
        .loopback (loopback),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] fq[$];
    logic [31:0] cq[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int          acc_cyc[$];
    int          ack_cyc[$];
    int          n_cmp, n_err, cyc, pops_f, pops_c, busy_cnt;
    logic        full_rand, stab_en, hdr_seen, prev_full;
    logic [31:0] prev_data;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    task automatic drive();
        bus.fifo_empty_i  = (fq.size() == 0);
        bus.fifo_data_i   = (fq.size() > 0) ? fq[0] : 24'h0;
        bus.fifo_enough_i = (fq.size() >= 4);
        bus.cpu_data_i    = (cq.size() > 0) ? cq[0] : 32'h0;
        bus.ft_full_i     = full_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    task automatic step();
        logic rf, rc;
        @(negedge clk);
        cyc++;
        if (stab_en && prev_full && hdr_seen)
            check_val("hold_data", bus.data_o, prev_data);
        prev_full = bus.ft_full_i;
        prev_data = bus.data_o;
        if (bus.busy_o && bus.data_o == 32'h0000_0004) hdr_seen = 1'b1;
        if (bus.we_o) begin
            got.push_back(bus.data_o);
            acc_cyc.push_back(cyc);
        end
        if (bus.cpu_ack_o) ack_cyc.push_back(cyc);
        if (bus.busy_o) busy_cnt++;
        rf = bus.fifo_rd_o;
        rc = bus.cpu_rd_o;
        if (rf) pops_f++;
        if (rc) pops_c++;
        @(posedge clk);
        #1;
        if (rf && fq.size() > 0) void'(fq.pop_front());
        if (rc && cq.size() > 0) void'(cq.pop_front());
        drive();
    endtask

    task automatic clear_log();
        got.delete();
        acc_cyc.delete();
        ack_cyc.delete();
        pops_f   = 0;
        pops_c   = 0;
        busy_cnt = 0;
        hdr_seen = 1'b0;
        prev_full = 1'b0;
    endtask

    task automatic check_stream(input string name);
        check_val($sformatf("%s_count", name), 32'(got.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            check_val($sformatf("%s_word%0d", name, i),
                      (i < got.size()) ? got[i] : 32'hxxxx_xxxx, exp_q[i]);
    endtask

    task automatic check_ack_lat(input string name);
        if (ack_cyc.size() > 0 && acc_cyc.size() > 0)
            check_val(name, 32'(ack_cyc[0] - acc_cyc[$]), 32'd1);
        else
            check_val(name, 32'(ack_cyc.size()), 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        full_rand = 1'b0; stab_en = 1'b0; prev_data = '0;
        clear_log();
        reset_n  = 1'b0;
        loopback = 1'b0;
        bus.cpu_req_i = 1'b0;
        bus.cpu_len_i = 8'd0;
        bus.cpu_tag_i = 20'd0;
        drive();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_we",    32'(bus.we_o),      32'd0);
        check_val("rst_data",  bus.data_o,         32'd0);
        check_val("rst_fifo_rd", 32'(bus.fifo_rd_o), 32'd0);
        check_val("rst_cpu_rd",  32'(bus.cpu_rd_o),  32'd0);
        check_val("rst_ack",   32'(bus.cpu_ack_o), 32'd0);
        check_val("rst_busy",  32'(bus.busy_o),    32'd0);
        reset_n = 1'b1;
        repeat (2) step();
        check_val("idle_busy", 32'(busy_cnt), 32'd0);

        // plain FIFO burst
        clear_log();
        fq = '{24'h7FF001, 24'h800FFF, 24'h123456, 24'hABCDEF};
        drive();
        for (int i = 0; i < 30 && got.size() < 5; i++) step();
        repeat (3) step();
        exp_q = '{32'h0000_0004, 32'h07FF_0001, 32'hF800_FFFF, 32'h0123_0456, 32'hFABC_FDEF};
        check_stream("fifo");
        check_val("fifo_pops", 32'(pops_f), 32'd4);
        if (acc_cyc.size() >= 5) check_val("fifo_nogap", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
        else                     check_val("fifo_nogap", 32'(acc_cyc.size()), 32'd5);
        check_val("fifo_no_ack", 32'(ack_cyc.size()), 32'd0);

        // CPU message, len 2
        clear_log();
        cq = '{32'hDEAD_BEEF, 32'h1234_5678};
        bus.cpu_len_i = 8'd2;
        bus.cpu_tag_i = 20'h00ABC;
        bus.cpu_req_i = 1'b1;
        drive();
        for (int i = 0; i < 30 && ack_cyc.size() == 0; i++) step();
        bus.cpu_req_i = 1'b0;
        repeat (3) step();
        exp_q = '{32'h8020_0ABC, 32'hDEAD_BEEF, 32'h1234_5678};
        check_stream("cpu2");
        check_val("cpu2_pops", 32'(pops_c), 32'd2);
        check_val("cpu2_acks", 32'(ack_cyc.size()), 32'd1);
        check_ack_lat("cpu2_ack_lat");

        // both requesting from reset: CPU, FIFO, CPU, FIFO
        @(posedge clk); #1;
        reset_n = 1'b0;
        clear_log();
        cq = '{32'hC000_0001, 32'hC000_0002};
        fq = '{24'h001002, 24'hFFF000, 24'h7FF800, 24'h800001,
               24'h0AB0CD, 24'hF00F00, 24'h555AAA, 24'h0007FF};
        bus.cpu_len_i = 8'd1;
        bus.cpu_tag_i = 20'h00001;
        bus.cpu_req_i = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 100 && got.size() < 14; i++) begin
            step();
            if (ack_cyc.size() == 1) bus.cpu_tag_i = 20'h00002;
            if (ack_cyc.size() >= 2) bus.cpu_req_i = 1'b0;
        end
        bus.cpu_req_i = 1'b0;
        repeat (3) step();
        exp_q = '{32'h8010_0001, 32'hC000_0001,
                  32'h0000_0004, 32'h0001_0002, 32'hFFFF_0000, 32'h07FF_F800, 32'hF800_0001,
                  32'h8010_0002, 32'hC000_0002,
                  32'h0000_0004, 32'h00AB_00CD, 32'hFF00_FF00, 32'h0555_FAAA, 32'h0000_07FF};
        check_stream("rr");
        check_val("rr_acks", 32'(ack_cyc.size()), 32'd2);
        check_val("rr_fifo_pops", 32'(pops_f), 32'd8);

        // write-port backpressure during a FIFO burst
        clear_log();
        fq = '{24'h100200, 24'h300400, 24'h500600, 24'h7FF7FF};
        stab_en   = 1'b1;
        full_rand = 1'b1;
        drive();
        for (int i = 0; i < 150 && got.size() < 5; i++) step();
        full_rand = 1'b0;
        repeat (4) step();
        stab_en = 1'b0;
        exp_q = '{32'h0000_0004, 32'h0100_0200, 32'h0300_0400, 32'h0500_0600, 32'h07FF_07FF};
        check_stream("bp");
        check_val("bp_pops", 32'(pops_f), 32'd4);

        // zero-length CPU message
        clear_log();
        bus.cpu_len_i = 8'd0;
        bus.cpu_tag_i = 20'h00001;
        bus.cpu_req_i = 1'b1;
        drive();
        for (int i = 0; i < 30 && ack_cyc.size() == 0; i++) step();
        bus.cpu_req_i = 1'b0;
        repeat (3) step();
        exp_q = '{32'h8000_0001};
        check_stream("len0");
        check_val("len0_pops", 32'(pops_c), 32'd0);
        check_val("len0_acks", 32'(ack_cyc.size()), 32'd1);
        check_ack_lat("len0_ack_lat");

        // loopback: raw words, CPU ignored
        clear_log();
        loopback = 1'b1;
        cq = '{32'hCAFE_F00D};
        bus.cpu_len_i = 8'd1;
        bus.cpu_tag_i = 20'h00005;
        bus.cpu_req_i = 1'b1;
        fq = '{24'h0AB0CD, 24'hF00F00, 24'h555AAA};
        drive();
        repeat (10) step();
        bus.cpu_req_i = 1'b0;
        cq.delete();
        loopback = 1'b0;
        drive();
        repeat (2) step();
        exp_q = '{32'h00AB_00CD, 32'hFF00_FF00, 32'h0555_FAAA};
        check_stream("lb");
        check_val("lb_busy", 32'(busy_cnt), 32'd0);
        check_val("lb_fifo_pops", 32'(pops_f), 32'd3);
        check_val("lb_cpu_pops", 32'(pops_c), 32'd0);
        check_val("lb_acks", 32'(ack_cyc.size()), 32'd0);

        // reset in the middle of a burst
        clear_log();
        fq = '{24'h7FF001, 24'h800FFF, 24'h123456, 24'hABCDEF};
        drive();
        for (int i = 0; i < 30 && pops_f < 2; i++) step();
        reset_n = 1'b0;
        #2;
        check_val("mrst_we",      32'(bus.we_o),      32'd0);
        check_val("mrst_data",    bus.data_o,         32'd0);
        check_val("mrst_fifo_rd", 32'(bus.fifo_rd_o), 32'd0);
        check_val("mrst_busy",    32'(bus.busy_o),    32'd0);
        fq.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_log();
        repeat (3) step();
        check_val("mrst_idle", 32'(busy_cnt + got.size()), 32'd0);
        clear_log();
        fq = '{24'h001002, 24'hFFF000, 24'h7FF800, 24'h800001};
        drive();
        for (int i = 0; i < 30 && got.size() < 5; i++) step();
        repeat (3) step();
        exp_q = '{32'h0000_0004, 32'h0001_0002, 32'hFFFF_0000, 32'h07FF_F800, 32'hF800_0001};
        check_stream("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
